// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: datapath widths, fetch FSM states and
// redirect-source encoding with its priority selector.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        ID_T  = 2'd1,
        EX_T  = 2'd2,
        EX_NT = 2'd3
    } redirect_src_e;

    // EX corrections are older than the ID guess, so they always win.
    function automatic redirect_src_e redirect_sel(input logic mis_to_nt,
                                                   input logic mis_to_t,
                                                   input logic id_redirect);
        if (mis_to_nt)        return EX_NT;
        else if (mis_to_t)    return EX_T;
        else if (id_redirect) return ID_T;
        else                  return SEQ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for fetch performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch stage: PC register with branch redirects, imem handshake
// FSM, IF/ID pipeline register and the ID/EX flush for EX mispredicts.
module fetch_redirect_unit #(
    parameter int                      PC_W     = cpu_pkg::PC_W,
    parameter int                      INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]         RESET_PC = '0,
    parameter int                      CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               id_is_beq,
    input  logic [PC_W-1:0]    id_target,
    input  logic               pred_taken,
    input  logic               mis_to_t,
    input  logic               mis_to_nt,
    input  logic [PC_W-1:0]    ex_target,
    input  logic [PC_W-1:0]    ex_pc_plus1,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               id_ex_flush,
    output logic [CNT_W-1:0]   mispredict_cnt,
    output logic [CNT_W-1:0]   taken_cnt
);

    import cpu_pkg::*;

    logic [PC_W-1:0] pc;
    fetch_state_e    state;
    redirect_src_e   src;
    logic            ex_redirect;
    logic            id_redirect;

    assign ex_redirect = mis_to_t | mis_to_nt;
    // A stalled or empty ID slot cannot steer fetch.
    assign id_redirect = id_is_beq & pred_taken & if_id_valid & ~stall;
    assign src         = redirect_sel(mis_to_nt, mis_to_t, id_redirect);
    assign imem_addr   = pc;
    assign id_ex_flush = ex_redirect & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= RUN;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else begin
            // An EX redirect abandons any outstanding fetch.
            if (ex_redirect) begin
                state <= RUN;
            end else begin
                case (state)
                    RUN:     if (!imem_ready) state <= MEMWAIT;
                    MEMWAIT: if (imem_ready)  state <= RUN;
                    default: state <= RUN;
                endcase
            end

            case (src)
                EX_NT: begin
                    pc          <= ex_pc_plus1;
                    if_id_valid <= 1'b0;
                end
                EX_T: begin
                    pc          <= ex_target;
                    if_id_valid <= 1'b0;
                end
                ID_T: begin
                    pc          <= id_target;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            pc          <= pc + 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc    <= pc;
                            if_id_valid <= 1'b1;
                        end else begin
                            if_id_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (ex_redirect),
        .count (mispredict_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (src == ID_T),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed-vector bench for fetch_redirect_unit (narrow counters to reach saturation).
module tb_fetch_redirect_unit;
    import cpu_pkg::*;

    localparam int PW = 8;
    localparam int IW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ready;
    logic          stall;
    logic          id_is_beq;
    logic [PW-1:0] id_target;
    logic          pred_taken;
    logic          mis_to_t;
    logic          mis_to_nt;
    logic [PW-1:0] ex_target;
    logic [PW-1:0] ex_pc_plus1;
    logic [IW-1:0] if_id_instr;
    logic [PW-1:0] if_id_pc;
    logic          if_id_valid;
    logic          id_ex_flush;
    logic [CW-1:0] mispredict_cnt;
    logic [CW-1:0] taken_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 16'h1000 + {8'h00, imem_addr};

    fetch_redirect_unit #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .id_is_beq      (id_is_beq),
        .id_target      (id_target),
        .pred_taken     (pred_taken),
        .mis_to_t       (mis_to_t),
        .mis_to_nt      (mis_to_nt),
        .ex_target      (ex_target),
        .ex_pc_plus1    (ex_pc_plus1),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .id_ex_flush    (id_ex_flush),
        .mispredict_cnt (mispredict_cnt),
        .taken_cnt      (taken_cnt)
    );

    typedef struct {
        logic       rst, rdy, stl, beq, pred, mt, mnt;
        logic [7:0] idt, ext, expc1;
        logic [7:0] e_pc;
        logic       e_valid;
        logic [7:0] e_ifpc;
        logic       e_flush;
        int         e_mcnt, e_tcnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic r, rdy, stl, beq, pred, mt, mnt,
                                input logic [7:0] idt, ext, expc1, epc,
                                input logic evld, input logic [7:0] eifpc,
                                input logic efl, input int emc, etc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.stl = stl; v.beq = beq; v.pred = pred;
        v.mt = mt; v.mnt = mnt; v.idt = idt; v.ext = ext; v.expc1 = expc1;
        v.e_pc = epc; v.e_valid = evld; v.e_ifpc = eifpc; v.e_flush = efl;
        v.e_mcnt = emc; v.e_tcnt = etc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, rdy, stl, beq, pred, mt, mnt,
                         input logic [7:0] idt, ext, expc1);
        rst = r; imem_ready = rdy; stall = stl; id_is_beq = beq;
        pred_taken = pred; mis_to_t = mt; mis_to_nt = mnt;
        id_target = idt; ex_target = ext; ex_pc_plus1 = expc1;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        drive(v.rst, v.rdy, v.stl, v.beq, v.pred, v.mt, v.mnt, v.idt, v.ext, v.expc1);
        #1;
        chk($sformatf("v%0d flush", i), int'(id_ex_flush), int'(v.e_flush));
        step();
        chk($sformatf("v%0d pc", i), int'(imem_addr), int'(v.e_pc));
        chk($sformatf("v%0d valid", i), int'(if_id_valid), int'(v.e_valid));
        chk($sformatf("v%0d if_id_pc", i), int'(if_id_pc), int'(v.e_ifpc));
        chk($sformatf("v%0d mispredict_cnt", i), int'(mispredict_cnt), v.e_mcnt);
        chk($sformatf("v%0d taken_cnt", i), int'(taken_cnt), v.e_tcnt);
        if (v.e_valid)
            chk($sformatf("v%0d instr", i), int'(if_id_instr), 32'h1000 + int'(v.e_ifpc));
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        //            rst rdy stl beq prd mt mnt idt    ext    pc1    |pc    vld ifpc   fl  mc tc
        vecs[0]  = mk(1, 1, 0, 0, 0, 1, 0, 8'h00, 8'h55, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 8'h00, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 8'h01, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 8'h02, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 1, 8'h03, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 1, 1, 0, 0, 8'h20, 8'h00, 8'h00, 8'h20, 0, 8'h03, 0, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h21, 1, 8'h20, 0, 0, 1);
        vecs[8]  = mk(0, 1, 0, 0, 0, 1, 1, 8'h00, 8'h40, 8'h11, 8'h11, 0, 8'h20, 1, 1, 1);
        vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 1, 8'h11, 0, 1, 1);
        vecs[10] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 1, 8'h11, 0, 1, 1);
        vecs[11] = mk(0, 1, 1, 1, 1, 0, 0, 8'h66, 8'h00, 8'h00, 8'h12, 1, 8'h11, 0, 1, 1);
        vecs[12] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 1, 8'h11, 0, 1, 1);
        vecs[13] = mk(0, 1, 1, 0, 0, 1, 0, 8'h00, 8'h30, 8'h00, 8'h30, 0, 8'h11, 1, 2, 1);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h31, 1, 8'h30, 0, 2, 1);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 8'h30, 1, 3, 1);
        vecs[16] = mk(0, 1, 0, 1, 1, 0, 0, 8'h77, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 0, 3, 1);
        vecs[17] = mk(0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h10, 8'h00, 8'h10, 0, 8'hFF, 1, 3, 1);
        vecs[18] = mk(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h12, 8'h12, 0, 8'hFF, 1, 3, 1);

        for (int i = 0; i < 19; i++)
            run_vec(vecs[i], i);

        // Memory wait, EX redirect out of MEMWAIT, then reset mid-wait.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step();
        chk("mw reset pc", int'(imem_addr), 0);
        chk("mw reset state", int'(dut.state), int'(RUN));
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("mw pc before wait", int'(imem_addr), 7);
        imem_ready = 1'b0;
        step();
        chk("mw state wait1", int'(dut.state), int'(MEMWAIT));
        chk("mw pc wait1", int'(imem_addr), 7);
        chk("mw valid wait1", int'(if_id_valid), 0);
        step();
        chk("mw state wait2", int'(dut.state), int'(MEMWAIT));
        chk("mw pc wait2", int'(imem_addr), 7);
        mis_to_nt = 1'b1;
        ex_pc_plus1 = 8'h09;
        #1;
        chk("mw flush", int'(id_ex_flush), 1);
        step();
        mis_to_nt = 1'b0;
        chk("mw redirect pc", int'(imem_addr), 9);
        chk("mw redirect state", int'(dut.state), int'(RUN));
        chk("mw redirect valid", int'(if_id_valid), 0);
        chk("mw mispredict_cnt", int'(mispredict_cnt), 1);
        step();
        chk("mw wait3 state", int'(dut.state), int'(MEMWAIT));
        chk("mw wait3 pc", int'(imem_addr), 9);
        imem_ready = 1'b1;
        step();
        chk("mw resume state", int'(dut.state), int'(RUN));
        chk("mw resume pc", int'(imem_addr), 8'h0A);
        chk("mw resume valid", int'(if_id_valid), 1);
        chk("mw resume if_id_pc", int'(if_id_pc), 9);
        chk("mw resume instr", int'(if_id_instr), 32'h1009);
        imem_ready = 1'b0;
        step();
        chk("mw wait4 state", int'(dut.state), int'(MEMWAIT));
        rst = 1'b1;
        step();
        chk("mw rst pc", int'(imem_addr), 0);
        chk("mw rst state", int'(dut.state), int'(RUN));
        chk("mw rst valid", int'(if_id_valid), 0);
        chk("mw rst mispredict_cnt", int'(mispredict_cnt), 0);
        chk("mw rst if_id_instr", int'(if_id_instr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch stage that consumes the branch predictor's outputs: predicted-taken, mispredict-to-taken and mispredict-to-not-taken.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Generates the ID/EX flush.
- Sits directly upstream of decode.

Parameters:
- PC_W, 8, PC / instruction-address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- imem_addr  out  PC_W  fetch address; equals pc
- imem_rdata  in  INSTR_W  instruction returned for imem_addr
- imem_ready  in  1  imem_rdata valid this cycle
- stall  in  1  decode hazard; hold IF/ID and PC
- id_is_beq  in  1  instruction in ID is beq
- id_target  in  PC_W  branch target computed in ID
- pred_taken  in  1  predictor says taken
- mis_to_t  in  1  EX: predicted not-taken, actually taken
- mis_to_nt  in  1  EX: predicted taken, actually not-taken
- ex_target  in  PC_W  branch target of the EX branch
- ex_pc_plus1  in  PC_W  fall-through PC of the EX branch
- if_id_instr  out  INSTR_W  IF/ID instruction
- if_id_pc  out  PC_W  IF/ID PC
- if_id_valid  out  1  IF/ID holds a live instruction
- id_ex_flush  out  1  kill the instruction entering ID/EX this cycle
- mispredict_cnt  out  CNT_W  number of EX redirects
- taken_cnt  out  CNT_W  number of ID predicted-taken redirects

Behaviour:
- Reset (rst=1 at a clk edge, including mid-operation):
  - pc=RESET_PC; if_id_valid=0; if_id_instr=0; if_id_pc=0; both counters=0; state=RUN.
  - id_ex_flush is combinational and is 0 while rst is high.
- FSM, 2 states: RUN and MEMWAIT.
  - RUN & !imem_ready -> MEMWAIT.
  - MEMWAIT & imem_ready -> RUN.
  - Any EX redirect -> RUN; the outstanding fetch is abandoned and imem_addr changes the next cycle.
- Redirect priority (highest first), evaluated every cycle:
  - mis_to_nt: pc<=ex_pc_plus1.
  - mis_to_t: pc<=ex_target.
  - id_redirect = id_is_beq & pred_taken & if_id_valid & !stall: pc<=id_target.
  - Normal advance: pc<=pc+1 (mod 2^PC_W) when imem_ready & !stall.
  - Otherwise hold pc.
- mis_to_nt and mis_to_t may be asserted together; mis_to_nt wins.
- EX redirect (mis_to_t | mis_to_nt):
  - id_ex_flush=1 in the same cycle.
  - Next edge: if_id_valid<=0, regardless of stall or imem_ready.
  - mispredict_cnt += 1.
- ID redirect:
  - Next edge: if_id_valid<=0, dropping the wrong-path instruction fetched this cycle.
  - id_ex_flush stays 0; the branch itself proceeds.
  - taken_cnt += 1.
- Normal load (imem_ready & !stall & no redirect): if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1.
- stall & no EX redirect: IF/ID and pc hold; imem_rdata is ignored.
- !imem_ready & !stall & no redirect: if_id_valid<=0 (bubble); pc holds.
- Counters saturate at all-ones; no wrap.
- Fetch-to-IF/ID latency: 1 cycle after imem_ready.
- Predicted-taken penalty: 1 bubble.
- Mispredict penalty: 2 bubbles (IF/ID plus the flushed ID/EX).

Decomposition:
- Shared package (cpu_pkg):
  - PC_W and INSTR_W constants.
  - FSM state encoding: RUN=1'b0, MEMWAIT=1'b1.
  - Redirect-source encoding, 2 bits: SEQ, ID_T, EX_T, EX_NT.
- One sub-module: sat_counter (CNT_W, inc, clr).
  - Instantiated twice for mispredict_cnt and taken_cnt.
- PC mux, FSM and IF/ID register stay in the top module.

Test Plan:
- Reset/sequential:
  - Stimulus: rst 2 cycles, imem_ready=1, rdata=0x1000+addr.
  - Required: pc goes 0,1,2,3; if_id_pc lags pc by 1; if_id_valid=1 from cycle 2; counters=0.
- ID predicted-taken:
  - Stimulus: at pc=4, id_is_beq=1, pred_taken=1, id_target=0x20.
  - Required: next pc=0x20; if_id_valid=0 for one cycle; taken_cnt=1; id_ex_flush=0.
- Both EX mispredict flags:
  - Stimulus: mis_to_t=1 and mis_to_nt=1, ex_pc_plus1=0x11, ex_target=0x40.
  - Required: pc=0x11; id_ex_flush=1 that cycle; if_id_valid=0 next; mispredict_cnt=1.
- Stall vs mispredict:
  - Stimulus: stall=1 for 3 cycles.
  - Required: pc and IF/ID frozen.
  - Stimulus: mis_to_t=1 with ex_target=0x30 during the stall.
  - Required: pc=0x30 and if_id_valid=0 despite the stall.
- Memory wait:
  - Stimulus: imem_ready=0 for 2 cycles at pc=7, then mis_to_nt with ex_pc_plus1=0x09.
  - Required: state MEMWAIT -> RUN; bubbles inserted; pc=0x09.
  - Stimulus: drive rst=1 mid-wait.
  - Required: pc=0, state=RUN.
- Saturation:
  - Stimulus: CNT_W=2, five mispredicts.
  - Required: mispredict_cnt sticks at 3.
